// File: rtl/analyzer_pkg.sv
// analyzer_pkg: shared widths and sequencer state encoding for the capture path.
package analyzer_pkg;
   localparam int DATA_WIDTH  = 8;
   localparam int ADDR_WIDTH  = 4;
   localparam int MEMORY_SIZE = 16;
   typedef enum logic [2:0] {IDLE, CLEAR, ARMED, TRIG, DONE, READ} state_t;
endpackage

// File: rtl/trig_match.sv
// trig_match: masked equality compare; a zero mask always matches.
module trig_match #(
   parameter int W = 8
) (
   input  logic [W-1:0] i_data,
   input  logic [W-1:0] i_value,
   input  logic [W-1:0] i_mask,
   output logic         o_match
);
   assign o_match = ((i_data ^ i_value) & i_mask) == '0;
endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: arms, triggers and freezes the circular sample buffer, then replays it oldest first.
module capture_ctrl
   import analyzer_pkg::*;
#(
   parameter int DATA_WIDTH  = analyzer_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH  = analyzer_pkg::ADDR_WIDTH,
   parameter int MEMORY_SIZE = analyzer_pkg::MEMORY_SIZE
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  arm,
   input  logic                  abort,
   input  logic                  sample_valid,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic [DATA_WIDTH-1:0] trig_value,
   input  logic [DATA_WIDTH-1:0] trig_mask,
   input  logic [ADDR_WIDTH-1:0] post_count,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic                  primed,
   output logic                  write_enable,
   output logic                  mem_clr,
   output logic [ADDR_WIDTH-1:0] trig_addr,
   output logic                  done,
   input  logic                  rd_start,
   output logic [ADDR_WIDTH-1:0] raddr,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic                  rd_last
);
   state_t                r_state, w_next;
   logic [ADDR_WIDTH-1:0] r_cnt, r_idx, r_trig_addr, r_raddr;
   logic                  w_match, w_hit;

   trig_match #(.W(DATA_WIDTH)) u_match (
      .i_data (i_data),
      .i_value(trig_value),
      .i_mask (trig_mask),
      .o_match(w_match)
   );

   assign w_hit        = sample_valid && w_match && primed;
   assign write_enable = sample_valid && (r_state == ARMED || r_state == TRIG);
   assign mem_clr      = r_state == IDLE || r_state == CLEAR;
   assign done         = r_state == DONE;
   assign rd_valid     = r_state == READ;
   assign rd_last      = rd_valid && r_idx == ADDR_WIDTH'(MEMORY_SIZE - 1);
   assign trig_addr    = r_trig_addr;
   assign raddr        = r_raddr;

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    w_next = arm ? CLEAR : IDLE;
         CLEAR:   w_next = ARMED;
         ARMED:   w_next = w_hit ? (post_count == '0 ? DONE : TRIG) : ARMED;
         TRIG:    w_next = (sample_valid && r_cnt == ADDR_WIDTH'(1)) ? DONE : TRIG;
         DONE:    w_next = arm ? CLEAR : (rd_start ? READ : DONE);
         READ:    w_next = (rd_ready && rd_last) ? DONE : READ;
         default: w_next = IDLE;
      endcase
      if (abort) w_next = IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_trig_addr <= '0;
         r_raddr     <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == ARMED && w_hit) begin
            r_trig_addr <= waddr;
            r_cnt       <= post_count;
         end
         if (r_state == TRIG && sample_valid) r_cnt <= r_cnt - 1'b1;
         // waddr is frozen in DONE and already points past the newest write, i.e. at the oldest sample
         if (r_state == DONE && w_next == READ) begin
            r_raddr <= waddr;
            r_idx   <= '0;
         end
         if (r_state == READ && rd_ready) begin
            r_raddr <= r_raddr + 1'b1;
            r_idx   <= r_idx + 1'b1;
         end
      end
   end
endmodule
